mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for a shared 2-to-1 datapath mux.
//   Two requesters present data beats with valid/ready handshakes. The block
//   picks one per cycle, drives the mux select, and registers the selected
//   beat into a one-entry output stage with its own valid/ready handshake.
//   It also keeps saturating per-requester grant counters for debug.
//   Sits between two producers and one consumer of a shared data lane.
// PARAMETERS
//   DATA_W  8  width of each data beat
//   CNT_W   8  width of each saturating grant counter
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active-high
//   in0_valid  in   1       requester 0 has a beat
//   in0_data   in   DATA_W  requester 0 beat
//   in0_ready  out  1       requester 0 beat accepted this cycle
//   in1_valid  in   1       requester 1 has a beat
//   in1_data   in   DATA_W  requester 1 beat
//   in1_ready  out  1       requester 1 beat accepted this cycle
//   out_valid  out  1       output stage holds a beat
//   out_data   out  DATA_W  registered muxed beat
//   out_sel    out  1       source of out_data (0=in0, 1=in1)
//   out_ready  in   1       consumer accepts the out beat
//   cnt0       out  CNT_W   beats accepted from in0 (saturating)
//   cnt1       out  CNT_W   beats accepted from in1 (saturating)
// BEHAVIOUR
//   Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, cnt0=cnt1=0,
//     internal last-grant pointer last=1, so in0 wins the first tie.
//   Output stage has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
//   can_load = !out_valid | out_ready. This is combinational.
//   Grant is combinational and only valid when can_load=1:
//     only in0_valid: grant 0. Only in1_valid: grant 1.
//     Both valid: grant ~last. Neither valid: no grant.
//   inN_ready = can_load & grant==N. At most one ready is high per cycle.
//     Ready may depend on valid.
//   Accept (on the clk edge) when inN_valid & inN_ready:
//     out_data<=inN_data, out_sel<=N, out_valid<=1, last<=N, cntN++.
//     cntN saturates at 2^CNT_W-1.
//   can_load with no valid input: out_valid<=0. out_data and out_sel hold.
//   FULL with out_ready=0: out_data and out_sel stay stable, both readies are 0.
//   FULL with out_ready=1 and a new grant: drain and reload in the same cycle.
//     This gives full throughput, one beat per cycle.
//   Latency: an input accepted at edge k appears on out_* right after edge k.
//   The pointer only moves on an accept. A lone requester does not lose
//     fairness: after it is served, the other requester wins the next tie.
//   Reset mid-operation discards any held beat with no handshake.
//     Producers re-present after reset.
//   Width rules: counters are unsigned. Data passes through unmodified.
// TESTING
//   1. Reset, then in0_valid=1 with in0_data=8'hA5, out_ready=1
//      -> in0_ready=1. Next cycle out_valid=1, out_data=A5, out_sel=0, cnt0=1.
//   2. Both valid every cycle, in0=8'h11, in1=8'h22, out_ready=1
//      -> out_data is 11,22,11,22 with out_sel 0,1,0,1. After 4 beats cnt0=cnt1=2.
//   3. Hold FULL with out_ready=0 for 3 cycles while both valid
//      -> out_data stable, in0_ready=in1_ready=0. When out_ready goes 1,
//      the other requester is accepted the same cycle.
//   4. CNT_W=2, 5 beats from in1 only -> cnt1 stays at 3. Every beat out_sel=1.
//   5. Assert rst mid-cycle while out_valid=1 -> out_valid=0 immediately,
//      counters 0. First tie after release is granted to in0.
//   6. in1 alone for 2 beats, then both valid -> next grant goes to in0.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two valid/ready requesters sharing a 2-to-1 data lane,
// with a one-entry registered output stage and saturating per-requester grant counters.
module mux2_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_r;
  state_t              state_next_s;
  logic                last_r;
  logic [DATA_W-1:0]   data_r;
  logic                sel_r;
  logic [CNT_W-1:0]    cnt0_r;
  logic [CNT_W-1:0]    cnt1_r;
  logic                can_load_s;
  logic                grant_valid_s;
  logic                grant_s;
  logic                accept_s;

  // Grant selection, handshake readies and output-stage next state.
  always_comb begin
    can_load_s    = (state_r == EMPTY) | out_ready;
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    state_next_s  = state_r;
    case ({in1_valid, in0_valid})
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b1;
      end
      2'b11: begin
        // Tie goes to whoever was not served most recently.
        grant_valid_s = 1'b1;
        grant_s       = ~last_r;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
      end
    endcase
    accept_s  = can_load_s & grant_valid_s;
    in0_ready = accept_s & ~grant_s;
    in1_ready = accept_s & grant_s;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_next_s = FULL;
        else          state_next_s = EMPTY;
      end
      FULL: begin
        if (out_ready) state_next_s = accept_s ? FULL : EMPTY;
        else           state_next_s = FULL;
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Output-stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= EMPTY;
    else     state_r <= state_next_s;
  end

  // Data/select capture, fairness pointer and saturating grant counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {DATA_W{1'b0}};
      sel_r  <= 1'b0;
      last_r <= 1'b1;
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      data_r <= grant_s ? in1_data : in0_data;
      sel_r  <= grant_s;
      last_r <= grant_s;
      if (!grant_s && cnt0_r != CNT_MAX) cnt0_r <= cnt0_r + CNT_ONE;
      if (grant_s && cnt1_r != CNT_MAX)  cnt1_r <= cnt1_r + CNT_ONE;
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;
  assign out_sel   = sel_r;
  assign cnt0      = cnt0_r;
  assign cnt1      = cnt1_r;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomized and directed bench for mux2_rr_arbiter; a transaction-level model
// predicts readies, the output stage and grant counts for two counter widths.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid, out_ready;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready, out_valid, out_sel;
  logic [7:0] out_data, cnt0, cnt1;
  logic       s_in0_ready, s_in1_ready, s_out_valid, s_out_sel;
  logic [7:0] s_out_data;
  logic [1:0] s_cnt0, s_cnt1;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: the beat in the output slot, who was served last, beat totals
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_sel;
  int       m_last_served;
  int       m_total0, m_total1;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  mux2_rr_arbiter #(.DATA_W(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(s_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(s_in1_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_sel(s_out_sel),
    .out_ready(out_ready), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int sat(input int total, input int max_v);
    return (total > max_v) ? max_v : total;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_sel = 1'b0;
    m_last_served = 1; m_total0 = 0; m_total1 = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".out_valid"}, out_valid, m_valid);
    check_eq({tag, ".out_data"}, out_data, m_data);
    check_eq({tag, ".out_sel"}, out_sel, m_sel);
    check_eq({tag, ".cnt0"}, cnt0, sat(m_total0, 255));
    check_eq({tag, ".cnt1"}, cnt1, sat(m_total1, 255));
    check_eq({tag, ".s_out_valid"}, s_out_valid, m_valid);
    check_eq({tag, ".s_out_data"}, s_out_data, m_data);
    check_eq({tag, ".s_cnt0"}, s_cnt0, sat(m_total0, 3));
    check_eq({tag, ".s_cnt1"}, s_cnt1, sat(m_total1, 3));
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic cycle(input string tag, input bit v0, input bit [7:0] d0,
                       input bit v1, input bit [7:0] d1, input bit ordy);
    bit room, take0, take1;
    in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = ordy;
    #3;
    room  = !m_valid || ordy;
    take0 = room && v0 && (!v1 || m_last_served == 1);
    take1 = room && v1 && !take0;
    check_eq({tag, ".in0_ready"}, in0_ready, take0);
    check_eq({tag, ".in1_ready"}, in1_ready, take1);
    check_eq({tag, ".s_in0_ready"}, s_in0_ready, take0);
    check_eq({tag, ".s_in1_ready"}, s_in1_ready, take1);
    @(posedge clk); #1;
    if (take0) begin
      m_valid = 1'b1; m_data = d0; m_sel = 1'b0; m_last_served = 0; m_total0++;
    end else if (take1) begin
      m_valid = 1'b1; m_data = d1; m_sel = 1'b1; m_last_served = 1; m_total1++;
    end else if (room) begin
      m_valid = 1'b0;
    end
    check_outputs(tag);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs(tag);
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_outputs("reset");
    rst = 1'b0;

    // Single beat from in0
    cycle("t1", 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);

    // Alternation under constant contention
    mid_reset("t2rst");
    for (int i = 0; i < 4; i++) cycle("t2", 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);

    // Back-pressure holds the slot, then the other requester gets in
    for (int i = 0; i < 3; i++) cycle("t3hold", 1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
    cycle("t3go", 1'b1, 8'h33, 1'b1, 8'h44, 1'b1);

    // Saturation of the narrow counter
    mid_reset("t4rst");
    for (int i = 0; i < 5; i++) cycle("t4", 1'b0, 8'h00, 1'b1, 8'(8'h50 + i), 1'b1);

    // Reset with a beat held, then the first tie goes to in0
    cycle("t5fill", 1'b1, 8'h66, 1'b0, 8'h00, 1'b0);
    mid_reset("t5rst");
    cycle("t5tie", 1'b1, 8'h77, 1'b1, 8'h88, 1'b1);

    // Lone in1 keeps its place in the rotation
    mid_reset("t6rst");
    cycle("t6a", 1'b0, 8'h00, 1'b1, 8'h91, 1'b1);
    cycle("t6b", 1'b0, 8'h00, 1'b1, 8'h92, 1'b1);
    cycle("t6tie", 1'b1, 8'h93, 1'b1, 8'h94, 1'b1);

    // Randomized traffic, long enough to saturate the wide counters too
    mid_reset("rndrst");
    for (int i = 0; i < 1500; i++) begin
      cycle("rnd", ($urandom_range(0, 9) < 8), 8'($urandom),
            ($urandom_range(0, 9) < 6), 8'($urandom),
            ($urandom_range(0, 9) < 8));
      if (i == 1400) mid_reset("rndmid");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
